// File: rtl/mem_port_rr_arbiter_pkg.sv
// Shared constants and helpers for the memory-port arbiters.
package mem_port_rr_arbiter_pkg;

    localparam int NUM_PE_DEFAULT  = 3;
    localparam int AW_DEFAULT      = 32;
    localparam int DW_DEFAULT      = 32;
    localparam int MEM_LAT_DEFAULT = 1;

    // Width of a requester index; never below one bit so a single-PE build still has a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_rr_arbiter_rr_pick.sv
// Round-robin pick: first set candidate at or above ptr_i, wrapping modulo N.
// Purely combinational so the grant lands in the same cycle as the request.
module mem_port_rr_arbiter_rr_pick
    import mem_port_rr_arbiter_pkg::*;
#(
    parameter int N  = NUM_PE_DEFAULT,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  cand_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o
);

    logic found;
    int   pos;

    // Scan from the pointer upward; the first hit wins and later hits are ignored.
    always_comb begin
        onehot_o = '0;
        found    = 1'b0;
        pos      = 0;
        for (int off = 0; off < N; off++) begin
            pos = int'(ptr_i) + off;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found && cand_i[IW'(pos)]) begin
                onehot_o[IW'(pos)] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_rr_arbiter.sv
// Shares one SRAM port among NUM_PE requesters: round-robin with a static
// high-priority override, fixed-latency response pipe routing data back.
module mem_port_rr_arbiter
    import mem_port_rr_arbiter_pkg::*;
#(
    parameter int NUM_PE  = NUM_PE_DEFAULT,
    parameter int AW      = AW_DEFAULT,
    parameter int DW      = DW_DEFAULT,
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_PE-1:0]        i_hp_mask,
    input  logic [NUM_PE-1:0]        i_req,
    input  logic [NUM_PE*AW-1:0]     i_addr,
    input  logic [NUM_PE*DW-1:0]     i_wdata,
    input  logic [NUM_PE-1:0]        i_we,
    input  logic [NUM_PE*DW/8-1:0]   i_be,
    output logic [NUM_PE-1:0]        o_gnt,
    output logic [NUM_PE-1:0]        o_rvalid,
    output logic [NUM_PE*DW-1:0]     o_rdata,
    input  logic                     i_mem_ready,
    output logic                     o_mem_req,
    output logic [AW-1:0]            o_mem_addr,
    output logic [DW-1:0]            o_mem_wdata,
    output logic                     o_mem_we,
    output logic [DW/8-1:0]          o_mem_be,
    input  logic [DW-1:0]            i_mem_rdata
);

    localparam int IW = idx_width(NUM_PE);
    localparam int BW = DW / 8;

    logic [NUM_PE-1:0] hp_req;
    logic [NUM_PE-1:0] cand;
    logic [NUM_PE-1:0] winner;
    logic [IW-1:0]     win_idx;
    logic [IW-1:0]     rr_ptr_q;

    logic              pipe_vld_q [MEM_LAT];
    logic [IW-1:0]     pipe_idx_q [MEM_LAT];
    logic              out_vld;
    logic [IW-1:0]     out_idx;

    // High-priority requesters shadow everyone else whenever any of them is asking.
    assign hp_req = i_req & i_hp_mask;
    assign cand   = (|hp_req) ? hp_req : i_req;

    mem_port_rr_arbiter_rr_pick #(
        .N  (NUM_PE),
        .IW (IW)
    ) u_rr_pick (
        .cand_i   (cand),
        .ptr_i    (rr_ptr_q),
        .onehot_o (winner)
    );

    assign o_mem_req = (|i_req) & i_mem_ready;
    assign o_gnt     = winner & {NUM_PE{o_mem_req}};

    // Encode the one-hot winner so it can travel down the response pipe.
    always_comb begin
        win_idx = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            if (winner[k]) begin
                win_idx = IW'(k);
            end
        end
    end

    // Steer the winner's request onto the SRAM port; idle port drives zeros.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_we    = 1'b0;
        o_mem_be    = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            if (o_mem_req && winner[k]) begin
                o_mem_addr  = i_addr[k*AW +: AW];
                o_mem_wdata = i_wdata[k*DW +: DW];
                o_mem_we    = i_we[k];
                o_mem_be    = i_be[k*BW +: BW];
            end
        end
    end

    generate
        if (NUM_PE > 1) begin : g_ptr
            logic [IW-1:0] rr_ptr_d;

            // Next pointer sits just past the accepted winner; a stalled port leaves it alone.
            always_comb begin
                rr_ptr_d = rr_ptr_q;
                if (o_mem_req) begin
                    rr_ptr_d = (win_idx == IW'(NUM_PE - 1)) ? '0 : win_idx + 1'b1;
                end
            end

            // Round-robin pointer register.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    rr_ptr_q <= '0;
                end else begin
                    rr_ptr_q <= rr_ptr_d;
                end
            end
        end else begin : g_ptr_fixed
            // A lone requester has nothing to rotate through.
            assign rr_ptr_q = '0;
        end
    endgenerate

    // Response pipe: stage 0 captures each accepted request, later stages just delay it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < MEM_LAT; s++) begin
                pipe_vld_q[s] <= 1'b0;
                pipe_idx_q[s] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= o_mem_req;
            pipe_idx_q[0] <= win_idx;
            for (int s = 1; s < MEM_LAT; s++) begin
                pipe_vld_q[s] <= pipe_vld_q[s-1];
                pipe_idx_q[s] <= pipe_idx_q[s-1];
            end
        end
    end

    assign out_vld = pipe_vld_q[MEM_LAT-1];
    assign out_idx = pipe_idx_q[MEM_LAT-1];

    // Demux the SRAM read data to whichever requester owns the response leaving the pipe.
    generate
        for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_resp
            assign o_rvalid[gi]          = out_vld && (out_idx == IW'(gi));
            assign o_rdata[gi*DW +: DW]  = o_rvalid[gi] ? i_mem_rdata : '0;
        end
    endgenerate

endmodule

// File: tb/tb_mem_port_rr_arbiter.sv
// Self-checking bench for mem_port_rr_arbiter: reference arbitration model,
// response scoreboard and a small behavioural SRAM behind the port.
module tb_mem_port_rr_arbiter;

    localparam int NUM_PE  = 3;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int MEM_LAT = 2;
    localparam int BW      = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_PE-1:0]    hp_mask = '0;
    logic [NUM_PE-1:0]    req     = '0;
    logic [NUM_PE*AW-1:0] addr    = '0;
    logic [NUM_PE*DW-1:0] wdata   = '0;
    logic [NUM_PE-1:0]    we      = '0;
    logic [NUM_PE*BW-1:0] be      = '0;
    logic [NUM_PE-1:0]    gnt;
    logic [NUM_PE-1:0]    rvalid;
    logic [NUM_PE*DW-1:0] rdata;
    logic                 mem_ready = 1'b1;
    logic                 mem_req;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic                 mem_we;
    logic [BW-1:0]        mem_be;
    logic [DW-1:0]        mem_rdata;

    mem_port_rr_arbiter #(
        .NUM_PE (NUM_PE), .AW (AW), .DW (DW), .MEM_LAT (MEM_LAT)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_hp_mask   (hp_mask),
        .i_req       (req),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .i_we        (we),
        .i_be        (be),
        .o_gnt       (gnt),
        .o_rvalid    (rvalid),
        .o_rdata     (rdata),
        .i_mem_ready (mem_ready),
        .o_mem_req   (mem_req),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_we    (mem_we),
        .o_mem_be    (mem_be),
        .i_mem_rdata (mem_rdata)
    );

    // Unwritten words read back as an address-dependent pattern so reads carry real data.
    function automatic logic [DW-1:0] init_word(input int i);
        return 32'hA5A5_0000 | DW'(i << 2);
    endfunction

    function automatic logic [DW-1:0] merge_be(input logic [DW-1:0] base, input logic [DW-1:0] d,
                                               input logic [BW-1:0] b);
        logic [DW-1:0] r;
        r = base;
        for (int i = 0; i < BW; i++) if (b[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    // Behavioural SRAM with MEM_LAT read latency, read-before-write.
    logic [DW-1:0] sram [256];
    bit   [255:0]  sram_wr;
    logic [DW-1:0] rd_pipe [MEM_LAT];

    function automatic logic [DW-1:0] sram_rd(input logic [7:0] w);
        return sram_wr[w] ? sram[w] : init_word(int'(w));
    endfunction

    always @(posedge clk) begin
        if (mem_req) begin
            rd_pipe[0] <= sram_rd(mem_addr[9:2]);
            if (mem_we) begin
                sram[mem_addr[9:2]]    <= merge_be(sram_rd(mem_addr[9:2]), mem_wdata, mem_be);
                sram_wr[mem_addr[9:2]] <= 1'b1;
            end
        end
        for (int s = 1; s < MEM_LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    // Reference memory, updated when the model predicts an accepted write.
    logic [DW-1:0] ref_mem [256];
    bit   [255:0]  ref_wr;

    typedef struct {
        int            due;
        int            pe;
        bit            is_wr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   m_ptr   = 0;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [NUM_PE-1:0] r, input logic [NUM_PE-1:0] hp, input int ptr);
        logic [NUM_PE-1:0] c;
        c = ((r & hp) != 0) ? (r & hp) : r;
        for (int o = 0; o < NUM_PE; o++) begin
            if (c[(ptr + o) % NUM_PE]) return (ptr + o) % NUM_PE;
        end
        return -1;
    endfunction

    task automatic set_pe(input int k, input bit r, input logic [AW-1:0] a, input bit w,
                          input logic [DW-1:0] d, input logic [BW-1:0] b);
        req[k]            = r;
        addr[k*AW +: AW]  = a;
        we[k]             = w;
        wdata[k*DW +: DW] = d;
        be[k*BW +: BW]    = b;
    endtask

    task automatic idle();
        req = '0;
        we  = '0;
    endtask

    // One clock: check grant/port/response against the model, advance the model, move to next negedge.
    task automatic tick();
        int                k;
        logic [NUM_PE-1:0] eg;
        logic [NUM_PE-1:0] er;
        logic [7:0]        w;
        exp_t              e;
        bit                have;
        #1;
        k  = model_pick(req, hp_mask, m_ptr);
        eg = '0;
        if (rst_n && mem_ready && k >= 0) eg[k] = 1'b1;
        chk("gnt", 64'(gnt), 64'(eg));
        chk("mem_req", 64'(mem_req), 64'(eg != 0));
        if (eg != 0) begin
            w = addr[k*AW + 2 +: 8];
            chk("mem_addr", 64'(mem_addr), 64'(addr[k*AW +: AW]));
            chk("mem_we", 64'(mem_we), 64'(we[k]));
            if (we[k]) begin
                chk("mem_wdata", 64'(mem_wdata), 64'(wdata[k*DW +: DW]));
                chk("mem_be", 64'(mem_be), 64'(be[k*BW +: BW]));
            end
            e.due   = cyc + MEM_LAT;
            e.pe    = k;
            e.is_wr = we[k];
            e.data  = ref_wr[w] ? ref_mem[w] : init_word(int'(w));
            if (we[k]) begin
                ref_mem[w] = merge_be(e.data, wdata[k*DW +: DW], be[k*BW +: BW]);
                ref_wr[w]  = 1'b1;
            end
            sb_q.push_back(e);
            m_ptr = (k + 1) % NUM_PE;
            $display("[TB] cyc %0d grant PE%0d %s addr 0x%0h", cyc, k, we[k] ? "WR" : "RD",
                     addr[k*AW +: AW]);
        end
        have = (sb_q.size() > 0) && (sb_q[0].due == cyc);
        er   = '0;
        if (have) begin
            e = sb_q.pop_front();
            er[e.pe] = 1'b1;
        end
        chk("rvalid", 64'(rvalid), 64'(er));
        for (int p = 0; p < NUM_PE; p++) begin
            if (have && p == e.pe) begin
                if (!e.is_wr) chk("rdata", 64'(rdata[p*DW +: DW]), 64'(e.data));
            end else begin
                chk("rdata_zero", 64'(rdata[p*DW +: DW]), 64'd0);
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset and a read that gets killed by a mid-flight reset.
        @(negedge clk);
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        tick();
        set_pe(1, 1'b1, 32'h20, 1'b0, '0, 4'hF);
        tick();
        idle();
        rst_n = 1'b0;
        sb_q.delete();
        m_ptr = 0;
        tick();
        tick();
        rst_n = 1'b1;
        drain(3);
        // Pointer is back at 0, so PE1 beats PE2.
        set_pe(1, 1'b1, 32'h24, 1'b0, '0, 4'hF);
        set_pe(2, 1'b1, 32'h28, 1'b0, '0, 4'hF);
        tick();
        drain(MEM_LAT + 1);
        // All three requesting continuously with no priority override.
        for (int k = 0; k < NUM_PE; k++) set_pe(k, 1'b1, 32'(16 * k), 1'b0, '0, 4'hF);
        for (int i = 0; i < 7; i++) tick();
        drain(MEM_LAT + 1);
        // PE2 alone, back-to-back reads.
        for (int i = 0; i < 3; i++) begin
            set_pe(2, 1'b1, 32'h100 + 32'(4 * i), 1'b0, '0, 4'hF);
            tick();
        end
        drain(MEM_LAT + 1);
        // High-priority override on PE1, then PE1 releases.
        hp_mask = 3'b010;
        set_pe(0, 1'b1, 32'h30, 1'b0, '0, 4'hF);
        set_pe(1, 1'b1, 32'h34, 1'b0, '0, 4'hF);
        for (int i = 0; i < 4; i++) tick();
        req[1] = 1'b0;
        tick();
        drain(MEM_LAT + 1);
        hp_mask = '0;
        // SRAM stall with PE0 and PE2 waiting.
        set_pe(0, 1'b1, 32'h50, 1'b0, '0, 4'hF);
        set_pe(2, 1'b1, 32'h54, 1'b0, '0, 4'hF);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        mem_ready = 1'b1;
        tick();
        drain(MEM_LAT + 1);
        // Write then read-back through a different requester.
        set_pe(0, 1'b1, 32'h40, 1'b1, 32'hDEAD_BEEF, 4'hF);
        tick();
        idle();
        set_pe(1, 1'b1, 32'h40, 1'b0, '0, 4'hF);
        tick();
        drain(MEM_LAT + 1);
        // Random traffic.
        hp_mask = 3'($urandom_range(0, 7)) & 3'b101;
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < NUM_PE; k++)
                set_pe(k, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255) * 4),
                       1'($urandom_range(0, 1)), 32'($urandom), 4'($urandom_range(0, 15)));
            mem_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        mem_ready = 1'b1;
        hp_mask   = '0;
        drain(MEM_LAT + 2);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
